// File: rtl/rvvi_retire_serializer.sv
// Multi-hart, multi-issue RVVI retirement collector: batches valid lanes into a shared FIFO
// and streams them one per cycle, tracking per-hart order continuity and halt state.
module rvvi_retire_serializer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned ILEN  = 32,
   parameter int unsigned NHART = 2,
   parameter int unsigned ISSUE = 2,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned NL   = NHART * ISSUE,
   localparam int unsigned HW   = (NHART > 1) ? $clog2(NHART) : 1,
   localparam int unsigned IW   = (ISSUE > 1) ? $clog2(ISSUE) : 1,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NL-1:0]      in_valid,
   input  logic [NL*64-1:0]   in_order,
   input  logic [NL*ILEN-1:0] in_insn,
   input  logic [NL*XLEN-1:0] in_pc_rdata,
   input  logic [NL*XLEN-1:0] in_pc_wdata,
   input  logic [NL-1:0]      in_trap,
   input  logic [NL-1:0]      in_halt,
   input  logic [NL*2-1:0]    in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [HW-1:0]      out_hart,
   output logic [IW-1:0]      out_issue,
   output logic [63:0]        out_order,
   output logic [ILEN-1:0]    out_insn,
   output logic [XLEN-1:0]    out_pc_rdata,
   output logic [XLEN-1:0]    out_pc_wdata,
   output logic               out_trap,
   output logic               out_halt,
   output logic [1:0]         out_mode,
   output logic [CW-1:0]      count,
   output logic               err_order,
   output logic [HW-1:0]      err_order_hart,
   output logic               err_halt,
   output logic               overflow,
   output logic [15:0]        drop_count
);

   localparam int unsigned PW = $clog2(DEPTH);

   // Entry storage; never reset, validity is tracked by count_q
   logic [HW-1:0]   mem_hart   [DEPTH];
   logic [IW-1:0]   mem_issue  [DEPTH];
   logic [63:0]     mem_order  [DEPTH];
   logic [ILEN-1:0] mem_insn   [DEPTH];
   logic [XLEN-1:0] mem_pc_r   [DEPTH];
   logic [XLEN-1:0] mem_pc_w   [DEPTH];
   logic            mem_trap   [DEPTH];
   logic            mem_halt   [DEPTH];
   logic [1:0]      mem_mode   [DEPTH];

   logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   k, free;
   logic            accept, pop;
   logic [PW-1:0]   slot [NL];

   logic [NHART-1:0] seeded_q, seeded_d;
   logic [NHART-1:0] halted_q, halted_d;
   logic [63:0]      exp_q [NHART];
   logic [63:0]      exp_d [NHART];
   logic             err_order_q, err_order_d;
   logic [HW-1:0]    err_hart_q, err_hart_d;
   logic             err_halt_q, err_halt_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_q, drop_d;

   // Admission uses pre-pop occupancy, so a same-cycle pop never makes room for the batch
   always_comb begin
      logic [PW-1:0] off;
      k   = '0;
      off = '0;
      for (int unsigned l = 0; l < NL; l++) begin
         k       = k + CW'(in_valid[l]);
         slot[l] = wr_q + off;
         if (in_valid[l]) off = off + PW'(1);
      end
      free    = CW'(DEPTH) - count_q;
      accept  = (k <= free);
      pop     = (count_q != '0) && out_ready;
      count_d = count_q + (accept ? k : '0) - CW'(pop);
      wr_d    = accept ? wr_q + PW'(k) : wr_q;
      rd_d    = rd_q + PW'(pop);

      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (!accept) begin
         overflow_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
   end

   // Lanes of a hart are walked in issue order so same-cycle lanes chain through the tracker
   always_comb begin
      seeded_d    = seeded_q;
      halted_d    = halted_q;
      exp_d       = exp_q;
      err_order_d = err_order_q;
      err_hart_d  = err_hart_q;
      err_halt_d  = err_halt_q;
      for (int unsigned h = 0; h < NHART; h++) begin
         for (int unsigned i = 0; i < ISSUE; i++) begin
            int unsigned l;
            l = h * ISSUE + i;
            if (in_valid[l]) begin
               if (halted_d[h]) err_halt_d = 1'b1;
               if (seeded_d[h] && (in_order[l*64 +: 64] != exp_d[h]) && !err_order_d) begin
                  err_order_d = 1'b1;
                  err_hart_d  = HW'(h);
               end
               seeded_d[h] = 1'b1;
               exp_d[h]    = in_order[l*64 +: 64] + 64'd1;
               if (in_halt[l]) halted_d[h] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q        <= '0;
         wr_q        <= '0;
         count_q     <= '0;
         seeded_q    <= '0;
         halted_q    <= '0;
         err_order_q <= 1'b0;
         err_hart_q  <= '0;
         err_halt_q  <= 1'b0;
         overflow_q  <= 1'b0;
         drop_q      <= '0;
         for (int unsigned h = 0; h < NHART; h++) exp_q[h] <= '0;
      end else begin
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         count_q     <= count_d;
         seeded_q    <= seeded_d;
         halted_q    <= halted_d;
         err_order_q <= err_order_d;
         err_hart_q  <= err_hart_d;
         err_halt_q  <= err_halt_d;
         overflow_q  <= overflow_d;
         drop_q      <= drop_d;
         exp_q       <= exp_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned l = 0; l < NL; l++) begin
         if (!reset && accept && in_valid[l]) begin
            mem_hart[slot[l]]  <= HW'(l / ISSUE);
            mem_issue[slot[l]] <= IW'(l % ISSUE);
            mem_order[slot[l]] <= in_order[l*64 +: 64];
            mem_insn[slot[l]]  <= in_insn[l*ILEN +: ILEN];
            mem_pc_r[slot[l]]  <= in_pc_rdata[l*XLEN +: XLEN];
            mem_pc_w[slot[l]]  <= in_pc_wdata[l*XLEN +: XLEN];
            mem_trap[slot[l]]  <= in_trap[l];
            mem_halt[slot[l]]  <= in_halt[l];
            mem_mode[slot[l]]  <= in_mode[l*2 +: 2];
         end
      end
   end

   assign out_valid      = (count_q != '0);
   assign out_hart       = out_valid ? mem_hart[rd_q]  : '0;
   assign out_issue      = out_valid ? mem_issue[rd_q] : '0;
   assign out_order      = out_valid ? mem_order[rd_q] : '0;
   assign out_insn       = out_valid ? mem_insn[rd_q]  : '0;
   assign out_pc_rdata   = out_valid ? mem_pc_r[rd_q]  : '0;
   assign out_pc_wdata   = out_valid ? mem_pc_w[rd_q]  : '0;
   assign out_trap       = out_valid ? mem_trap[rd_q]  : 1'b0;
   assign out_halt       = out_valid ? mem_halt[rd_q]  : 1'b0;
   assign out_mode       = out_valid ? mem_mode[rd_q]  : '0;
   assign count          = count_q;
   assign err_order      = err_order_q;
   assign err_order_hart = err_hart_q;
   assign err_halt       = err_halt_q;
   assign overflow       = overflow_q;
   assign drop_count     = drop_q;

endmodule
